ssd_scan: RTL and testbench

Four-digit time-multiplexed seven-segment display driver. Sits directly downstream of the BCD digit counters: takes four 4-bit digit values, latches them frame-synchronously, and drives the board's common-anode display one digit at a time. Scan rate comes from an internal refresh prescaler. Supports leading-zero blanking, decimal points and a global enable.

---
 rtl/ssd_pkg.sv | 53 +++++
 rtl/seg7_dec.sv | 15 +
 rtl/ssd_scan.sv | 123 ++++++++++++
 tb/tb_ssd_scan.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and hex glyph lookup for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

   localparam int unsigned DIGITS  = 4;
   localparam int unsigned DIG_W   = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned DATA_W  = DIGITS * DIG_W;

   localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A   = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B   = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C   = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D   = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E   = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F   = 7'b0001110;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
   localparam logic [DIGITS-1:0] AN_OFF = 4'hF;

   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [DIG_W-1:0] i_val);
      logic [SEG_W-1:0] seg;
      seg = SEG_OFF;
      case (i_val)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational hex-to-segment decoder with a blank override.
module seg7_dec
   import ssd_pkg::*;
(
   input  logic [DIG_W-1:0] i_val,
   input  logic             i_blank,
   output logic [SEG_W-1:0] o_seg_c
);

   always_comb begin
      o_seg_c = SEG_OFF;
      if (!i_blank) o_seg_c = hex_to_seg(i_val);
   end

endmodule

// File: rtl/ssd_scan.sv
// Four-digit multiplexed common-anode display driver with frame-synchronous
// data swap, leading-zero blanking and decimal points.
module ssd_scan
   import ssd_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)(
   input  logic              ssd_scan_clk,
   input  logic              ssd_scan_rst_n,
   input  logic              ssd_scan_en,
   input  logic              ssd_scan_load,
   input  logic [DATA_W-1:0] ssd_scan_d,
   input  logic [DIGITS-1:0] ssd_scan_dp,
   input  logic              ssd_scan_lzb,
   output logic [DIGITS-1:0] ssd_scan_an,
   output logic [SEG_W-1:0]  ssd_scan_seg,
   output logic              ssd_scan_dpo,
   output logic              ssd_scan_frame
);

   localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]     r_presc;
   logic [1:0]        r_idx;
   logic [DATA_W-1:0] r_shadow_d;
   logic [DIGITS-1:0] r_shadow_dp;
   logic [DATA_W-1:0] r_active_d;
   logic [DIGITS-1:0] r_active_dp;
   logic              r_pending;
   logic [DIGITS-1:0] r_an;
   logic [SEG_W-1:0]  r_seg;
   logic              r_dpo;
   logic              r_frame;

   logic              w_tick;
   logic              w_wrap;
   logic [DIG_W-1:0]  w_digit;
   logic              w_blank;
   logic [SEG_W-1:0]  w_seg;

   assign w_tick  = (r_presc == PRESC_MAX);
   assign w_wrap  = w_tick && (r_idx == 2'd3);
   assign w_digit = r_active_d[{r_idx, 2'b00} +: DIG_W];

   // Refresh prescaler and digit index
   always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
      if (!ssd_scan_rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + PW'(1);
         if (w_tick) r_idx <= r_idx + 2'd1;
      end
   end

   // Shadow captures loads; active only swaps at a frame wrap so a frame is never torn
   always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
      if (!ssd_scan_rst_n) begin
         r_shadow_d  <= '0;
         r_shadow_dp <= '0;
         r_active_d  <= '0;
         r_active_dp <= '0;
         r_pending   <= 1'b0;
      end else begin
         if (ssd_scan_load) begin
            r_shadow_d  <= ssd_scan_d;
            r_shadow_dp <= ssd_scan_dp;
         end
         if (w_wrap && r_pending) begin
            r_active_d  <= r_shadow_d;
            r_active_dp <= r_shadow_dp;
         end
         if (ssd_scan_load)     r_pending <= 1'b1;
         else if (w_wrap)       r_pending <= 1'b0;
      end
   end

   // Digit k blanks only when it and all digits to its left are zero
   always_comb begin
      w_blank = 1'b0;
      if (ssd_scan_lzb) begin
         case (r_idx)
            2'd3:    w_blank = (r_active_d[15:12] == 4'h0);
            2'd2:    w_blank = (r_active_d[15:8]  == 8'h00);
            2'd1:    w_blank = (r_active_d[15:4]  == 12'h000);
            default: w_blank = 1'b0;
         endcase
      end
   end

   seg7_dec u_dec (
      .i_val   (w_digit),
      .i_blank (w_blank),
      .o_seg_c (w_seg)
   );

   always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst_n) begin
      if (!ssd_scan_rst_n) begin
         r_an    <= AN_OFF;
         r_seg   <= SEG_OFF;
         r_dpo   <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         r_frame <= w_wrap;
         if (ssd_scan_en) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg;
            r_dpo <= ~r_active_dp[r_idx];
         end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dpo <= 1'b1;
         end
      end
   end

   assign ssd_scan_an    = r_an;
   assign ssd_scan_seg   = r_seg;
   assign ssd_scan_dpo   = r_dpo;
   assign ssd_scan_frame = r_frame;

endmodule

// File: tb/tb_ssd_scan.sv
// Self-checking bench for ssd_scan with a 4-cycle digit slot (16-cycle frame).
module tb_ssd_scan;

   localparam int unsigned RD = 4;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110;
   localparam logic [6:0] GD = 7'b0100001;
   localparam logic [6:0] BL = 7'b1111111;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b1;
   logic        load  = 1'b0;
   logic        lzb   = 1'b0;
   logic [15:0] d     = '0;
   logic [3:0]  dp    = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dpo;
   logic        frame;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpo;
      logic       frame;
   } exp_t;

   typedef struct {
      logic [15:0]     d;
      logic [3:0]      dp;
      logic            lzb;
      logic [3:0][6:0] seg;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[4];

   ssd_scan #(.REFRESH_DIV(RD)) dut (
      .ssd_scan_clk   (clk),
      .ssd_scan_rst_n (rst_n),
      .ssd_scan_en    (en),
      .ssd_scan_load  (load),
      .ssd_scan_d     (d),
      .ssd_scan_dp    (dp),
      .ssd_scan_lzb   (lzb),
      .ssd_scan_an    (an),
      .ssd_scan_seg   (seg),
      .ssd_scan_dpo   (dpo),
      .ssd_scan_frame (frame)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_off(input string name);
      chk({name, " an"},    32'(an),    32'(4'hF));
      chk({name, " seg"},   32'(seg),   32'(BL));
      chk({name, " dpo"},   32'(dpo),   32'(1'b1));
   endtask

   task automatic wait_frame(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (frame !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (frame !== 1'b1) begin
         errors++;
         $display("FAIL %s: frame pulse not seen within 40 cycles", name);
      end
   endtask

   task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv);
      @(negedge clk);
      d    = dv;
      dp   = dpv;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Called on a frame-pulse cycle; checks the following 16 cycles of scan output.
   // Optionally drives a load in the cycle of the next frame-wrap tick.
   task automatic check_frame(input string name, input logic [3:0][6:0] s,
                              input logic [3:0] dpm, input bit inj, input logic [15:0] inj_d);
      exp_t e;
      int   k;
      for (int i = 0; i < 16; i++) begin
         k       = i / 4;
         e.an    = ~(4'b0001 << k);
         e.seg   = s[k];
         e.dpo   = ~dpm[k];
         e.frame = (i == 15);
         sb.push_back(e);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (inj && i == 14) begin
            d    = inj_d;
            dp   = 4'h0;
            load = 1'b1;
         end
         if (inj && i == 15) load = 1'b0;
         e = sb.pop_front();
         chk($sformatf("%s c%0d an", name, i),    32'(an),    32'(e.an));
         chk($sformatf("%s c%0d seg", name, i),   32'(seg),   32'(e.seg));
         chk($sformatf("%s c%0d dpo", name, i),   32'(dpo),   32'(e.dpo));
         chk($sformatf("%s c%0d frame", name, i), 32'(frame), 32'(e.frame));
      end
   endtask

   // After release: digit 0 for cycles 1..4, digit 1 from cycle 5, active all zero
   task automatic post_reset(input string name);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("%s cyc%0d an", name, c), 32'(an), 32'((c <= 4) ? 4'b1110 : 4'b1101));
         chk($sformatf("%s cyc%0d seg", name, c), 32'(seg), 32'(G0));
         chk($sformatf("%s cyc%0d dpo", name, c), 32'(dpo), 32'(1'b1));
      end
   endtask

   initial begin
      vecs[0].d = 16'h1234; vecs[0].dp = 4'b0000; vecs[0].lzb = 1'b0;
      vecs[0].seg = {G1, G2, G3, G4};
      vecs[1].d = 16'h0005; vecs[1].dp = 4'b0000; vecs[1].lzb = 1'b1;
      vecs[1].seg = {BL, BL, BL, G5};
      vecs[2].d = 16'h0000; vecs[2].dp = 4'b0000; vecs[2].lzb = 1'b1;
      vecs[2].seg = {BL, BL, BL, G0};
      vecs[3].d = 16'hABCD; vecs[3].dp = 4'b0100; vecs[3].lzb = 1'b0;
      vecs[3].seg = {GA, GB, GC, GD};

      // reset values held while rst_n is low
      @(negedge clk);
      chk_off("reset");
      chk("reset frame", 32'(frame), 32'(1'b0));
      post_reset("release");

      // table-driven vectors: load, let it swap in, then check a full frame
      foreach (vecs[v]) begin
         lzb = vecs[v].lzb;
         do_load(vecs[v].d, vecs[v].dp);
         wait_frame($sformatf("vec%0d sync", v));
         check_frame($sformatf("vec%0d", v), vecs[v].seg, vecs[v].dp, 1'b0, 16'h0);
      end

      // load coincident with the frame-wrap tick is deferred by one frame
      lzb = 1'b0;
      do_load(16'h1111, 4'h0);
      wait_frame("coinc sync");
      check_frame("coinc f0", {G1, G1, G1, G1}, 4'h0, 1'b1, 16'h2222);
      check_frame("coinc f1", {G1, G1, G1, G1}, 4'h0, 1'b0, 16'h0);
      check_frame("coinc f2", {G2, G2, G2, G2}, 4'h0, 1'b0, 16'h0);

      // disable mid-frame; scanning keeps going and resumes on the current digit
      repeat (5) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk_off("en0");
      wait_frame("en0 frame");
      repeat (8) @(negedge clk);
      chk_off("en0 late");
      en = 1'b1;
      @(negedge clk);
      chk("en1 an",  32'(an),  32'(4'b1011));
      chk("en1 seg", 32'(seg), 32'(G2));
      chk("en1 dpo", 32'(dpo), 32'(1'b1));

      // async reset between edges with a load pending
      do_load(16'h9999, 4'hF);
      #3;
      rst_n = 1'b0;
      #1;
      chk_off("async rst");
      chk("async rst frame", 32'(frame), 32'(1'b0));
      post_reset("rerelease");
      wait_frame("rst sync");
      check_frame("rst zero", {G0, G0, G0, G0}, 4'h0, 1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
